// File: rtl/popcount_ternary_neuron_seq.sv
// popcount_ternary_neuron_seq: streaming ternary neuron with popcount scoring and threshold activation
module popcount_ternary_neuron_seq #(
  parameter int WIDTH    = 18,
  parameter int BEATS    = 4,
  parameter int APX_BITS = 2,
  parameter int SUM_W    = $clog2(WIDTH*BEATS+1)+1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] w_pos,
  input  logic [WIDTH-1:0] w_neg,
  input  logic             approx_en,
  input  logic [SUM_W-1:0] threshold,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic             out_act
);
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [WIDTH-1:0] LOW = ({{(WIDTH-1){1'b0}}, 1'b1} << APX_BITS) - 1'b1;

  typedef enum logic {ACC, HOLD} state_t;

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [SUM_W-1:0] r_acc, r_thr, r_sum;
  logic             r_apx, r_act;
  logic             w_first, w_last, w_take, w_apx;
  logic [WIDTH-1:0] w_d;
  logic [SUM_W-1:0] w_c, w_tot, w_thr;

  assign in_ready  = (r_state == ACC);
  assign out_valid = (r_state == HOLD);
  assign out_sum   = r_sum;
  assign out_act   = r_act;

  // beat 0 uses the live frame controls, later beats use the latched copies
  assign w_first = (r_cnt == '0);
  assign w_last  = (r_cnt == CW'(BEATS-1));
  assign w_take  = in_valid & in_ready;
  assign w_apx   = w_first ? approx_en : r_apx;
  assign w_thr   = w_first ? threshold : r_thr;
  assign w_d     = w_apx ? (in_data & ~LOW) : in_data;
  assign w_tot   = w_first ? w_c : r_acc + w_c;

  // signed beat contribution: +1 per active positive weight, -1 per active negative weight
  always_comb begin
    w_c = '0;
    for (int i = 0; i < WIDTH; i++)
      w_c = w_c + SUM_W'(w_d[i] & w_pos[i]) - SUM_W'(w_d[i] & w_neg[i]);
  end

  // next state: finish a frame on its last beat, release on the result handshake
  always_comb begin
    w_next = r_state;
    if (r_state == ACC && w_take && w_last) w_next = HOLD;
    if (r_state == HOLD && out_ready) w_next = ACC;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= ACC;
    else        r_state <= w_next;

  // accumulation, frame-control latching and result capture
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_thr <= '0;
      r_apx <= 1'b0;
      r_sum <= '0;
      r_act <= 1'b0;
    end else if (w_take) begin
      r_acc <= w_tot;
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      if (w_first) begin
        r_thr <= threshold;
        r_apx <= approx_en;
      end
      if (w_last) begin
        r_sum <= w_tot;
        r_act <= $signed(w_tot) >= $signed(w_thr);
      end
    end
endmodule

// File: tb/tb_popcount_ternary_neuron_seq.sv
// tb_popcount_ternary_neuron_seq: directed self-checking bench for the ternary neuron
module tb_popcount_ternary_neuron_seq;
  localparam logic [17:0] ONES = 18'h3FFFF;

  logic              clk = 1'b0;
  logic              rst_n, in_valid, in_ready, approx_en, out_valid, out_ready, out_act;
  logic [17:0]       in_data, w_pos, w_neg;
  logic signed [7:0] threshold, out_sum;
  int                pass = 0, total = 0;

  popcount_ternary_neuron_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .w_pos(w_pos), .w_neg(w_neg), .approx_en(approx_en),
    .threshold(threshold), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_act(out_act)
  );

  always #5 clk = ~clk;

  task automatic beat(input logic [17:0] d, p, n, input logic a, input logic signed [7:0] t);
    in_data = d; w_pos = p; w_neg = n; approx_en = a; threshold = t; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic frame(input logic [17:0] d, p, n, input logic a, input logic signed [7:0] t);
    for (int k = 0; k < 4; k++) beat(d, p, n, a, t);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass++;
    total++; if (out_sum !== 8'sd0) $display("FAIL reset_out_sum got %0d want 0", out_sum); else pass++;
    total++; if (out_act !== 1'b0) $display("FAIL reset_out_act got %b want 0", out_act); else pass++;
  endtask

  task automatic test_max_pos();
    for (int k = 0; k < 3; k++) beat(ONES, ONES, 18'h0, 1'b0, 8'sd72);
    total++; if (out_valid !== 1'b0) $display("FAIL maxpos_early_valid got %b want 0", out_valid); else pass++;
    beat(ONES, ONES, 18'h0, 1'b0, 8'sd72);
    total++; if (out_valid !== 1'b1) $display("FAIL maxpos_valid got %b want 1", out_valid); else pass++;
    total++; if (in_ready !== 1'b0) $display("FAIL maxpos_in_ready got %b want 0", in_ready); else pass++;
    total++; if (out_sum !== 8'sd72) $display("FAIL maxpos_sum got %0d want 72", out_sum); else pass++;
    total++; if (out_act !== 1'b1) $display("FAIL maxpos_act got %b want 1", out_act); else pass++;
    release_result();
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL maxpos_release got rdy=%b vld=%b want 1/0", in_ready, out_valid); else pass++;
  endtask

  task automatic test_max_neg();
    frame(ONES, 18'h0, ONES, 1'b0, 8'sd0);
    total++; if (out_sum !== -8'sd72) $display("FAIL maxneg_sum got %0d want -72", out_sum); else pass++;
    total++; if (out_act !== 1'b0) $display("FAIL maxneg_act got %b want 0", out_act); else pass++;
    release_result();
  endtask

  task automatic test_approx();
    frame(18'h3, ONES, 18'h0, 1'b1, 8'sd0);
    total++; if (out_sum !== 8'sd0) $display("FAIL approx_on_sum got %0d want 0", out_sum); else pass++;
    release_result();
    frame(18'h3, ONES, 18'h0, 1'b0, 8'sd0);
    total++; if (out_sum !== 8'sd8) $display("FAIL approx_off_sum got %0d want 8", out_sum); else pass++;
    release_result();
    beat(18'h3, ONES, 18'h0, 1'b0, 8'sd0);
    beat(18'h3, ONES, 18'h0, 1'b0, 8'sd0);
    beat(18'h3, ONES, 18'h0, 1'b1, 8'sd0);
    beat(18'h3, ONES, 18'h0, 1'b1, 8'sd0);
    total++; if (out_sum !== 8'sd8) $display("FAIL approx_toggle_sum got %0d want 8", out_sum); else pass++;
    release_result();
  endtask

  task automatic test_overlap();
    frame(ONES, ONES, ONES, 1'b0, 8'sd0);
    total++; if (out_sum !== 8'sd0) $display("FAIL overlap_sum got %0d want 0", out_sum); else pass++;
    total++; if (out_act !== 1'b1) $display("FAIL overlap_act_t0 got %b want 1", out_act); else pass++;
    release_result();
    frame(ONES, ONES, ONES, 1'b0, 8'sd1);
    total++; if (out_act !== 1'b0) $display("FAIL overlap_act_t1 got %b want 0", out_act); else pass++;
    release_result();
  endtask

  task automatic test_backpressure();
    frame(ONES, ONES, 18'h0, 1'b0, 8'sd72);
    in_data = ONES; w_pos = 18'h0; w_neg = ONES; threshold = -8'sd100; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 8'sd72 || out_act !== 1'b1)
        $display("FAIL hold_cycle%0d got rdy=%b vld=%b sum=%0d act=%b want 0/1/72/1", k, in_ready, out_valid, out_sum, out_act);
      else pass++;
    end
    release_result();
    total++; if (in_ready !== 1'b1) $display("FAIL hold_release_ready got %b want 1", in_ready); else pass++;
    for (int k = 0; k < 3; k++) beat(18'h1, ONES, 18'h0, 1'b0, 8'sd4);
    total++; if (out_valid !== 1'b0) $display("FAIL next_early_valid got %b want 0", out_valid); else pass++;
    beat(18'h1, ONES, 18'h0, 1'b0, 8'sd4);
    total++; if (out_valid !== 1'b1 || out_sum !== 8'sd4 || out_act !== 1'b1) $display("FAIL next_frame got vld=%b sum=%0d act=%b want 1/4/1", out_valid, out_sum, out_act); else pass++;
    release_result();
  endtask

  task automatic test_gaps();
    beat(ONES, ONES, 18'h0, 1'b0, 8'sd72);
    in_data = 18'h0; w_neg = ONES; threshold = 8'sd100;
    repeat (2) @(posedge clk); #1;
    beat(ONES, ONES, 18'h0, 1'b1, 8'sd100);
    repeat (3) @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL gap_mid got vld=%b rdy=%b want 0/1", out_valid, in_ready); else pass++;
    beat(ONES, ONES, 18'h0, 1'b1, 8'sd100);
    beat(ONES, ONES, 18'h0, 1'b1, 8'sd100);
    total++; if (out_valid !== 1'b1 || out_sum !== 8'sd72 || out_act !== 1'b1) $display("FAIL gap_frame got vld=%b sum=%0d act=%b want 1/72/1", out_valid, out_sum, out_act); else pass++;
    release_result();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    frame(ONES, ONES, 18'h0, 1'b0, 8'sd72);
    total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 8'sd72) $display("FAIL b2b_first got vld=%b rdy=%b sum=%0d want 1/0/72", out_valid, in_ready, out_sum); else pass++;
    in_valid = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL b2b_handshake got rdy=%b vld=%b want 1/0", in_ready, out_valid); else pass++;
    frame(18'h1, ONES, 18'h0, 1'b0, 8'sd5);
    total++; if (out_valid !== 1'b1 || out_sum !== 8'sd4 || out_act !== 1'b0) $display("FAIL b2b_second got vld=%b sum=%0d act=%b want 1/4/0", out_valid, out_sum, out_act); else pass++;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    beat(ONES, ONES, 18'h0, 1'b0, 8'sd0);
    beat(ONES, ONES, 18'h0, 1'b0, 8'sd0);
    #2 rst_n = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 8'sd0) $display("FAIL async_reset got rdy=%b vld=%b sum=%0d want 1/0/0", in_ready, out_valid, out_sum); else pass++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) beat(18'h1, ONES, 18'h0, 1'b0, 8'sd0);
    total++; if (out_valid !== 1'b0) $display("FAIL rstmid_early_valid got %b want 0", out_valid); else pass++;
    beat(18'h1, ONES, 18'h0, 1'b0, 8'sd0);
    total++; if (out_valid !== 1'b1 || out_sum !== 8'sd4) $display("FAIL rstmid_sum got vld=%b sum=%0d want 1/4", out_valid, out_sum); else pass++;
    release_result();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; approx_en = 1'b0;
    in_data = '0; w_pos = '0; w_neg = '0; threshold = '0;
    #12;
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    test_max_pos();
    test_max_neg();
    test_approx();
    test_overlap();
    test_backpressure();
    test_gaps();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
